// File: rtl/pc_next_if.sv
// Control/datapath bundle for pc_next_unit: the control unit (or a bench) drives
// the master side, and pc_next_unit sits on the slave side.
interface pc_next_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       pc_src;
    logic             pc_write;
    logic             pc_write_cond;
    logic             branch_cond;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] jump_target;
    logic [WIDTH-1:0] alu_out;
    logic             epc_write;
    logic [WIDTH-1:0] epc_in;
    logic             exc_req;
    logic [1:0]       exc_code;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] epc;
    logic [1:0]       cause;
    logic             trap;
    logic             in_exc;
    logic             double_fault;

    modport master (
        output pc_src, pc_write, pc_write_cond, branch_cond, alu_result, jump_target,
               alu_out, epc_write, epc_in, exc_req, exc_code,
        input  pc, pc_next, epc, cause, trap, in_exc, double_fault
    );

    modport slave (
        input  pc_src, pc_write, pc_write_cond, branch_cond, alu_result, jump_target,
               alu_out, epc_write, epc_in, exc_req, exc_code,
        output pc, pc_next, epc, cause, trap, in_exc, double_fault
    );
endinterface

// File: rtl/pc_next_unit.sv
// PC/EPC register pair with a five-source next-PC mux, alignment and external
// exception trapping, and a two-state RUN/EXC handler FSM.
module pc_next_unit #(
    parameter int          WIDTH       = 32,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0080,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    pc_next_if.slave  bus
);
    localparam logic [0:0] S_RUN = 1'b0;
    localparam logic [0:0] S_EXC = 1'b1;

    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] EXC_V  = WIDTH'(EXC_VECTOR);

    logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d, pc_next;
    logic [1:0]       cause_q, cause_d;
    logic             trap_q, trap_d, df_q, df_d;
    logic [0:0]       state_q, state_d;
    logic             load, reserved, misalign, trap_en;

    always_comb begin
        pc_next = pc_q;
        case (bus.pc_src)
            3'b000:  pc_next = bus.alu_result;
            3'b001:  pc_next = bus.jump_target;
            3'b010:  pc_next = bus.alu_out;
            3'b011:  pc_next = epc_q;
            3'b100:  pc_next = EXC_V;
            default: pc_next = pc_q;
        endcase
    end

    assign load     = bus.pc_write | (bus.pc_write_cond & bus.branch_cond);
    assign reserved = (bus.pc_src > 3'b100);
    // The trap vector itself is never alignment-checked; reserved selects never trap.
    assign misalign = ALIGN_CHECK && load && (bus.pc_src < 3'b100) && (pc_next[1:0] != 2'b00);
    assign trap_en  = bus.exc_req | misalign;

    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        trap_d  = 1'b0;
        df_d    = df_q;
        state_d = state_q;
        if (trap_en) begin
            pc_d   = EXC_V;
            trap_d = 1'b1;
            if (state_q == S_RUN) begin
                epc_d   = bus.exc_req ? bus.epc_in : pc_q;
                cause_d = bus.exc_req ? bus.exc_code : 2'b11;
                state_d = S_EXC;
            end else begin
                // Nested trap: keep the first fault's EPC/cause for the handler.
                df_d = 1'b1;
            end
        end else begin
            if (bus.epc_write)
                epc_d = bus.epc_in;
            if (load && !reserved) begin
                pc_d = pc_next;
                if (bus.pc_src == 3'b011) begin
                    state_d = S_RUN;
                    cause_d = 2'b00;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RST_PC;
            epc_q   <= '0;
            cause_q <= 2'b00;
            trap_q  <= 1'b0;
            df_q    <= 1'b0;
            state_q <= S_RUN;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            trap_q  <= trap_d;
            df_q    <= df_d;
            state_q <= state_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.pc_next      = pc_next;
    assign bus.epc          = epc_q;
    assign bus.cause        = cause_q;
    assign bus.trap         = trap_q;
    assign bus.in_exc       = (state_q == S_EXC);
    assign bus.double_fault = df_q;
endmodule
